// File: rtl/noc_arb_mux.sv
// noc_arb_mux: NoC input arbiter and flit multiplexer into one output register.
// MODE=0 selects a port statically; MODE=1 locks the output to one packet at a time.
module noc_arb_mux #(
    parameter int NPORT = 4,
    parameter int DATAW = 66,
    parameter int VCHW  = 2,
    parameter int MODE  = 1,
    parameter int SELW  = 3
) (
    input  logic                   clk,
    input  logic                   rst_,
    input  logic [NPORT*DATAW-1:0] idata,
    input  logic [NPORT-1:0]       ivalid,
    input  logic [NPORT*VCHW-1:0]  ivch,
    output logic [NPORT-1:0]       iready,
    input  logic [SELW-1:0]        sel,
    output logic [DATAW-1:0]       odata,
    output logic                   ovalid,
    output logic [VCHW-1:0]        ovch,
    input  logic                   oready,
    output logic [NPORT-1:0]       grant
);

    localparam int PW = (NPORT > 1) ? $clog2(NPORT) : 1;

    localparam logic [1:0] T_HEAD = 2'b01;
    localparam logic [1:0] T_TAIL = 2'b11;

    typedef enum logic {
        S_IDLE,
        S_LOCKED
    } state_e;

    state_e state_q, state_d;

    logic [PW-1:0]    lock_q, lock_d;
    logic [PW-1:0]    last_q, last_d;
    logic [DATAW-1:0] odata_q, odata_d;
    logic [VCHW-1:0]  ovch_q, ovch_d;
    logic             ovalid_q, ovalid_d;

    logic [DATAW-1:0] flit  [NPORT];
    logic [VCHW-1:0]  vch   [NPORT];
    logic [1:0]       ftype [NPORT];

    logic             can_load;
    logic [NPORT-1:0] gnt;
    logic [NPORT-1:0] rdy;
    logic             head_found;
    logic [PW-1:0]    head_win;
    logic [DATAW-1:0] mux_flit;
    logic [VCHW-1:0]  mux_vch;
    logic             xfer;

    always_comb begin
        for (int p = 0; p < NPORT; p++) begin
            flit[p]  = idata[p*DATAW +: DATAW];
            vch[p]   = ivch[p*VCHW +: VCHW];
            ftype[p] = idata[p*DATAW + DATAW - 2 +: 2];
        end
    end

    assign can_load = ~ovalid_q | oready;

    // Rotating search for a HEAD, starting just after the last winner.
    always_comb begin
        int idx;
        idx        = 0;
        head_found = 1'b0;
        head_win   = '0;
        for (int i = 1; i <= NPORT; i++) begin
            idx = (int'(last_q) + i) % NPORT;
            if (!head_found && ivalid[idx] && ftype[idx] == T_HEAD) begin
                head_found = 1'b1;
                head_win   = PW'(idx);
            end
        end
    end

    always_comb begin
        gnt     = '0;
        state_d = state_q;
        lock_d  = lock_q;
        last_d  = last_q;
        if (MODE == 0) begin
            for (int p = 0; p < NPORT; p++) begin
                if (int'(sel) == p) begin
                    gnt[p] = 1'b1;
                end
            end
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (head_found) begin
                        gnt[head_win] = 1'b1;
                        if (can_load) begin
                            state_d = S_LOCKED;
                            lock_d  = head_win;
                            last_d  = head_win;
                        end
                    end
                end
                S_LOCKED: begin
                    gnt[lock_q] = 1'b1;
                    if (can_load && ivalid[lock_q] && ftype[lock_q] == T_TAIL) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
        if (!rst_) begin
            gnt = '0;
        end
    end

    assign rdy  = gnt & {NPORT{can_load}};
    assign xfer = |(ivalid & rdy);

    always_comb begin
        mux_flit = '0;
        mux_vch  = '0;
        for (int p = 0; p < NPORT; p++) begin
            if (gnt[p]) begin
                mux_flit = flit[p];
                mux_vch  = vch[p];
            end
        end
    end

    always_comb begin
        ovalid_d = ovalid_q;
        odata_d  = odata_q;
        ovch_d   = ovch_q;
        if (can_load) begin
            ovalid_d = xfer;
            if (xfer) begin
                odata_d = mux_flit;
                ovch_d  = mux_vch;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q  <= S_IDLE;
            lock_q   <= '0;
            last_q   <= PW'(NPORT - 1);
            ovalid_q <= 1'b0;
            odata_q  <= '0;
            ovch_q   <= '0;
        end else begin
            state_q  <= state_d;
            lock_q   <= lock_d;
            last_q   <= last_d;
            ovalid_q <= ovalid_d;
            odata_q  <= odata_d;
            ovch_q   <= ovch_d;
        end
    end

    assign grant  = gnt;
    assign iready = rdy;
    assign odata  = odata_q;
    assign ovalid = ovalid_q;
    assign ovch   = ovch_q;

endmodule

// File: tb/tb_noc_arb_mux.sv
// tb_noc_arb_mux: directed and random checks of noc_arb_mux in both modes
// against a packet-level reference model built from per-port flit queues.
module tb_noc_arb_mux;

    localparam int NP = 4;
    localparam int DW = 66;
    localparam int VW = 2;
    localparam int SW = 3;

    typedef logic [VW+DW-1:0] ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_;
    logic [NP*DW-1:0] idata;
    logic [NP-1:0]  ivalid;
    logic [NP*VW-1:0] ivch;
    logic [SW-1:0]  sel;
    logic           oready;

    logic [NP-1:0]  rr_iready, st_iready, rr_grant, st_grant;
    logic [DW-1:0]  rr_odata, st_odata;
    logic [VW-1:0]  rr_ovch, st_ovch;
    logic           rr_ovalid, st_ovalid;

    noc_arb_mux #(.NPORT(NP), .DATAW(DW), .VCHW(VW), .MODE(1), .SELW(SW)) u_rr (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .iready(rr_iready), .sel(sel), .odata(rr_odata), .ovalid(rr_ovalid),
        .ovch(rr_ovch), .oready(oready), .grant(rr_grant)
    );

    noc_arb_mux #(.NPORT(NP), .DATAW(DW), .VCHW(VW), .MODE(0), .SELW(SW)) u_st (
        .clk(clk), .rst_(rst_), .idata(idata), .ivalid(ivalid), .ivch(ivch),
        .iready(st_iready), .sel(sel), .odata(st_odata), .ovalid(st_ovalid),
        .ovch(st_ovch), .oready(oready), .grant(st_grant)
    );

    bit rr_ph;
    logic [NP-1:0] d_grant, d_iready;
    logic [DW-1:0] d_odata;
    logic [VW-1:0] d_ovch;
    logic          d_ovalid;
    assign d_grant  = rr_ph ? rr_grant  : st_grant;
    assign d_iready = rr_ph ? rr_iready : st_iready;
    assign d_odata  = rr_ph ? rr_odata  : st_odata;
    assign d_ovch   = rr_ph ? rr_ovch   : st_ovch;
    assign d_ovalid = rr_ph ? rr_ovalid : st_ovalid;

    ent_t srcq [NP][$];
    logic [NP-1:0] en;
    int ncmp = 0;
    int nfail = 0;

    int owner;
    int last;
    logic m_ov;
    logic [DW-1:0] m_od;
    logic [VW-1:0] m_oc;
    int win_log[$];

    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pay();
        return {$urandom, $urandom};
    endfunction

    task automatic mkpkt(int p, int nd, bit allow_none);
        logic [VW-1:0] vc;
        logic [1:0] t;
        vc = VW'($urandom);
        srcq[p].push_back({vc, 2'b01, pay()});
        for (int i = 0; i < nd; i++) begin
            t = (allow_none && $urandom_range(0, 7) == 0) ? 2'b00 : 2'b10;
            srcq[p].push_back({vc, t, pay()});
        end
        srcq[p].push_back({vc, 2'b11, pay()});
    endtask

    task automatic flush();
        for (int p = 0; p < NP; p++) srcq[p].delete();
    endtask

    task automatic drive();
        ent_t e;
        for (int p = 0; p < NP; p++) begin
            if (srcq[p].size() > 0) begin
                e = srcq[p][0];
                ivalid[p] = en[p];
                idata[p*DW +: DW] = e[DW-1:0];
                ivch[p*VW +: VW] = e[DW +: VW];
            end else begin
                ivalid[p] = 1'b0;
                idata[p*DW +: DW] = '0;
                ivch[p*VW +: VW] = '0;
            end
        end
    endtask

    // One clock: drive, check at negedge, then advance the model past the edge.
    task automatic step();
        logic [NP-1:0] eg, er;
        logic can;
        int xp;
        int q;
        ent_t e;
        drive();
        @(negedge clk);
        eg = '0;
        if (rst_) begin
            if (!rr_ph) begin
                if (sel < NP) eg[sel[1:0]] = 1'b1;
            end else if (owner >= 0) begin
                eg[owner] = 1'b1;
            end else begin
                for (int k = 1; k <= NP; k++) begin
                    q = (last + k) % NP;
                    if (eg == 0 && ivalid[q] && idata[q*DW + DW - 2 +: 2] == 2'b01)
                        eg[q] = 1'b1;
                end
            end
        end
        can = !m_ov || oready;
        er = can ? eg : '0;
        chk("grant", DW'(d_grant), DW'(eg));
        chk("iready", DW'(d_iready), DW'(er));
        chk("ovalid", DW'(d_ovalid), DW'(m_ov));
        if (m_ov) begin
            chk("odata", d_odata, m_od);
            chk("ovch", DW'(d_ovch), DW'(m_oc));
        end
        xp = -1;
        for (int p = 0; p < NP; p++) if (er[p] && ivalid[p]) xp = p;
        if (rr_ph && xp >= 0 && owner < 0) win_log.push_back(int'(rr_grant));
        @(posedge clk);
        #1;
        if (!rst_) begin
            m_ov = 1'b0;
            m_od = '0;
            m_oc = '0;
            owner = -1;
            last = NP - 1;
        end else begin
            if (can) m_ov = (xp >= 0);
            if (xp >= 0) begin
                e = srcq[xp].pop_front();
                m_od = e[DW-1:0];
                m_oc = e[DW +: VW];
                if (rr_ph) begin
                    if (owner < 0) begin
                        owner = xp;
                        last = xp;
                    end else if (e[DW-1 -: 2] == 2'b11) begin
                        owner = -1;
                    end
                end
            end
        end
    endtask

    function automatic bit busy();
        for (int p = 0; p < NP; p++) if (srcq[p].size() != 0) return 1'b1;
        return m_ov;
    endfunction

    task automatic drain(int maxc);
        int n;
        n = 0;
        while (busy() && n < maxc) begin
            step();
            n++;
        end
        ncmp++;
        assert (n < maxc) else begin
            nfail++;
            $error("FAIL drain: observed %0d cycles expected below %0d", n, maxc);
        end
    endtask

    initial begin
        rst_ = 1'b0;
        en = '0;
        oready = 1'b1;
        sel = '0;
        rr_ph = 1'b1;
        ivalid = '0;
        idata = '0;
        ivch = '0;
        owner = -1;
        last = NP - 1;
        m_ov = 1'b0;
        m_od = '0;
        m_oc = '0;
        repeat (2) @(posedge clk);
        #1;
        step();
        chk("rst_odata", rr_odata, '0);
        chk("rst_ovch", DW'(rr_ovch), '0);
        chk("rst_st_ovalid", DW'(st_ovalid), '0);
        rst_ = 1'b1;

        // two simultaneous packets, port 1 before port 3
        en = '1;
        mkpkt(1, 2, 0);
        mkpkt(3, 2, 0);
        drain(40);

        // all ports contend with short packets
        win_log.delete();
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++) mkpkt(p, 0, 0);
        drain(80);
        chk("rr_count", DW'(win_log.size()), DW'(8));
        for (int i = 0; i < 5 && i < win_log.size(); i++)
            chk("rr_order", DW'(win_log[i]), DW'(1 << (i % NP)));

        // stall mid-packet
        mkpkt(2, 4, 0);
        step();
        step();
        oready = 1'b0;
        repeat (3) step();
        oready = 1'b1;
        drain(40);

        // stray DATA on port 0 while a HEAD waits on port 2
        srcq[0].push_back({2'b00, 2'b10, pay()});
        mkpkt(2, 1, 0);
        repeat (8) step();
        flush();
        drain(5);

        // reset in the middle of a packet
        mkpkt(2, 3, 0);
        step();
        step();
        rst_ = 1'b0;
        step();
        rst_ = 1'b1;
        step();
        flush();
        srcq[2].push_back({2'b01, 2'b11, pay()});
        repeat (4) step();
        flush();
        drain(5);

        // random round-robin traffic
        repeat (1500) begin
            en = NP'($urandom);
            oready = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++)
                if (srcq[p].size() == 0 && $urandom_range(0, 3) == 0)
                    mkpkt(p, $urandom_range(0, 4), 1);
            rst_ = ($urandom_range(0, 199) != 0);
            step();
            if (!rst_) begin
                flush();
                rst_ = 1'b1;
            end
        end
        en = '1;
        oready = 1'b1;
        drain(400);

        // static mode
        rst_ = 1'b0;
        step();
        rst_ = 1'b1;
        rr_ph = 1'b0;
        sel = 3'd1;
        for (int i = 0; i < 20; i++) srcq[1].push_back({2'b10, 2'b10, pay()});
        drain(40);
        sel = 3'd5;
        srcq[1].push_back({2'b00, 2'b10, pay()});
        repeat (4) step();
        flush();
        drain(5);

        repeat (300) begin
            sel = SW'($urandom);
            en = NP'($urandom);
            oready = ($urandom_range(0, 3) != 0);
            for (int p = 0; p < NP; p++)
                if (srcq[p].size() < 2) srcq[p].push_back(ent_t'({$urandom, pay()}));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
